// File: rtl/fetch_queue.sv
// Instruction-fetch stage: owns the fetch PC, issues sequential reads to a
// 1-cycle-latency instruction memory and buffers returned words in a FIFO.
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  logic [31:0]   fifo_data [DEPTH];
  logic [31:0]   fifo_pc   [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          inflight;
  logic [31:0]   inflight_pc;
  logic [31:0]   fetch_pc;

  logic [CW:0]   occupancy;
  logic          push;
  logic          pop;
  logic          has_entry;

  // Slots reserved by an in-flight read count as occupied so a response can
  // never overrun the FIFO; a same-cycle pop deliberately frees nothing.
  assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign imem_req  = !rst && !redirect && (occupancy < (CW+1)'(DEPTH));
  assign imem_addr = fetch_pc;

  assign has_entry  = (count != '0);
  assign push       = inflight;
  assign pop        = has_entry && inst_ready;

  assign inst_valid = !rst && has_entry;
  assign inst_data  = inst_valid ? fifo_data[rd_ptr] : '0;
  assign inst_pc    = inst_valid ? fifo_pc[rd_ptr]   : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (redirect) begin
      // Flush wins over any response or pop arriving in the same cycle.
      fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      inflight <= 1'b0;
    end else begin
      if (imem_req) begin
        fetch_pc    <= fetch_pc + 32'd4;
        inflight    <= 1'b1;
        inflight_pc <= fetch_pc;
      end else begin
        inflight <= 1'b0;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !redirect && push) begin
      fifo_data[wr_ptr] <= imem_data;
      fifo_pc[wr_ptr]   <= inflight_pc;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: directed phases push expected PCs, a
// negedge monitor pops and compares every accepted instruction.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready = 1'b0;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  logic [31:0] exp_q[$];

  fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .inst_valid (inst_valid),
    .inst_data  (inst_data),
    .inst_pc    (inst_pc),
    .inst_ready (inst_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_0001;
  endfunction

  // Synchronous memory: fixed one-cycle read latency.
  always @(posedge clk) imem_data <= imem_req ? mem_word(imem_addr) : 32'hBAD0_BAD0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: consumes on handshake, ignoring pops in flush/reset cycles.
  always @(negedge clk) begin
    if (!rst && !redirect && inst_valid && inst_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pop", {32'd0, inst_pc}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk("pop_pc", {32'd0, inst_pc}, {32'd0, e});
        chk("pop_data", {32'd0, inst_data}, {32'd0, mem_word(e)});
      end
    end else if (!inst_valid) begin
      chk("idle_zero", {inst_pc, inst_data}, 64'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic end_phase(input string name);
    tick();
    rst = 1'b1;
    inst_ready = 1'b0;
    redirect = 1'b0;
    #1;
    chk({name, "_drain"}, {32'd0, 32'(exp_q.size())}, 64'd0);
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(); tick();
    #1;
    chk("reset_req", {63'd0, imem_req}, 64'd0);
    chk("reset_valid", {63'd0, inst_valid}, 64'd0);

    // Steady streaming from reset.
    for (int i = 0; i < 8; i++) exp_q.push_back(32'(i * 4));
    for (int c = 0; c < 10; c++) begin
      tick();
      rst = 1'b0; inst_ready = 1'b1;
      #1;
      if (c == 0) begin
        chk("s_req0", {63'd0, imem_req}, 64'd1);
        chk("s_addr0", {32'd0, imem_addr}, 64'h0);
        chk("s_valid0", {63'd0, inst_valid}, 64'd0);
      end
      if (c == 1) chk("s_addr1", {32'd0, imem_addr}, 64'h4);
      if (c == 2) chk("s_valid2", {63'd0, inst_valid}, 64'd1);
    end
    end_phase("stream");

    // Fill with consumer stalled, then drain.
    for (int i = 0; i < 10; i++) exp_q.push_back(32'(i * 4));
    for (int c = 0; c < 20; c++) begin
      tick();
      rst = 1'b0; inst_ready = (c >= 10);
      #1;
      if (c == 4) chk("f_req_stop", {63'd0, imem_req}, 64'd0);
      if (c == 9) begin
        chk("f_req_held", {63'd0, imem_req}, 64'd0);
        chk("f_pc_held", {32'd0, imem_addr}, 64'h10);
        chk("f_head_pc", {32'd0, inst_pc}, 64'h0);
      end
      if (c == 10) chk("f_req_popcycle", {63'd0, imem_req}, 64'd0);
      if (c == 11) chk("f_req_resume", {31'd0, imem_req, imem_addr}, {31'd0, 1'b1, 32'h10});
    end
    end_phase("fill");

    // Pop coinciding with a response at occupancy limit.
    for (int i = 0; i < 10; i++) exp_q.push_back(32'(i * 4));
    for (int c = 0; c < 14; c++) begin
      tick();
      rst = 1'b0; inst_ready = (c >= 4);
      #1;
      if (c == 4) chk("p_req_full", {63'd0, imem_req}, 64'd0);
      if (c == 5) chk("p_req_next", {31'd0, imem_req, imem_addr}, {31'd0, 1'b1, 32'h10});
    end
    end_phase("popresp");

    // Redirect with 3 entries queued and a read in flight.
    for (int i = 0; i < 6; i++) exp_q.push_back(32'h100 + 32'(i * 4));
    for (int c = 0; c < 13; c++) begin
      tick();
      rst = 1'b0;
      inst_ready = (c >= 4);
      redirect = (c == 4);
      redirect_pc = 32'h0000_0102;
      #1;
      if (c == 4) begin
        chk("r_req", {63'd0, imem_req}, 64'd0);
        chk("r_valid_preflush", {63'd0, inst_valid}, 64'd1);
      end
      if (c == 5) begin
        chk("r_valid_after", {63'd0, inst_valid}, 64'd0);
        chk("r_issue", {31'd0, imem_req, imem_addr}, {31'd0, 1'b1, 32'h100});
      end
      if (c == 6) chk("r_valid_c6", {63'd0, inst_valid}, 64'd0);
      if (c == 7) chk("r_valid_c7", {63'd0, inst_valid}, 64'd1);
    end
    end_phase("redirect");

    // PC wrap at the top of the address space.
    exp_q.push_back(32'hFFFF_FFF8); exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
    for (int c = 0; c < 8; c++) begin
      tick();
      rst = 1'b0; inst_ready = 1'b1;
      redirect = (c == 0);
      redirect_pc = 32'hFFFF_FFF8;
      #1;
      if (c == 1) chk("w_addr1", {32'd0, imem_addr}, 64'hFFFF_FFF8);
      if (c == 3) chk("w_addr_wrap", {32'd0, imem_addr}, 64'h0);
    end
    end_phase("wrap");

    // Back-to-back redirects: last one wins.
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h300 + 32'(i * 4));
    for (int c = 0; c < 8; c++) begin
      tick();
      rst = 1'b0; inst_ready = 1'b1;
      redirect = (c < 2);
      redirect_pc = (c == 0) ? 32'h200 : 32'h303;
      #1;
      if (c == 1) chk("b_req", {63'd0, imem_req}, 64'd0);
      if (c == 2) chk("b_issue", {31'd0, imem_req, imem_addr}, {31'd0, 1'b1, 32'h300});
    end
    end_phase("b2b");

    // Mid-stream reset with 2 entries queued.
    for (int i = 0; i < 3; i++) exp_q.push_back(32'(i * 4));
    for (int c = 0; c < 9; c++) begin
      tick();
      rst = (c == 3);
      inst_ready = (c >= 4);
      #1;
      if (c == 2) chk("m_valid_pre", {63'd0, inst_valid}, 64'd1);
      if (c == 3) chk("m_during", {62'd0, imem_req, inst_valid}, 64'd0);
      if (c == 4) begin
        chk("m_valid_after", {31'd0, inst_valid, inst_pc}, 64'd0);
        chk("m_issue", {31'd0, imem_req, imem_addr}, {31'd0, 1'b1, 32'h0});
      end
    end
    end_phase("midrst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
